// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//    Instruction fetch stage. Owns the program counter, issues instruction
//    memory reads, and buffers each returned word together with its address
//    in a small FIFO that decode drains. Taken branches/jumps flush the
//    buffer and restart fetching at the new target. A HALT word (opcode 6'h3F)
//    is still delivered, but no further requests are made until a redirect.
//
// Ports
//    CLK          in   1   clock, rising edge
//    RST          in   1   synchronous active-high reset
//    imemREN      out  1   instruction read request
//    imemaddr     out  32  fetch address (current PC)
//    imemload     in   32  instruction word, valid with ihit
//    ihit         in   1   memory completes the current request
//    redirect     in   1   flush and refetch from redirect_pc
//    redirect_pc  in   32  redirect target, low two bits ignored
//    id_ready     in   1   decode takes the head entry this cycle
//    id_valid     out  1   head entry valid
//    id_instr     out  32  head instruction word
//    id_pc        out  32  head instruction address
//    id_npc       out  32  head instruction address + 4
//    halted       out  1   fetching stopped after a HALT word
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] PC_INIT    = 32'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic [31:0] imemload,
    input  logic        ihit,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_npc,
    output logic        halted
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic {
        RUN,
        HALTED
    } fetchState_t;

    fetchState_t   state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [31:0]   instrBuf_q [FIFO_DEPTH];
    logic [31:0]   pcBuf_q    [FIFO_DEPTH];

    logic          reqActive;
    logic          doPush;
    logic          doPop;
    logic          isHalt;
    logic          bufNotEmpty;
    logic [31:0]   redirectTarget;
    logic          unusedRedirectBits;

    // A request is outstanding whenever we are running and have room to
    // store its result, so a full buffer naturally stalls the memory side.
    // Redirect overrides both push and pop: the incoming word is wrong-path
    // and whatever decode would have popped is flushed anyway.
    assign bufNotEmpty        = (count_q != '0);
    assign reqActive          = (state_q == RUN) && (count_q < DEPTH_C);
    assign doPush             = reqActive && ihit && !redirect;
    assign doPop              = bufNotEmpty && id_ready && !redirect;
    assign isHalt             = (imemload[31:26] == 6'h3F);
    assign redirectTarget     = {redirect_pc[31:2], 2'b00};
    assign unusedRedirectBits = ^redirect_pc[1:0];

    // Next-state logic for the PC, buffer pointers/occupancy and the
    // RUN/HALTED state. The PC only advances on an accepted word, so a slow
    // memory sees a stable address until it answers. After a HALT word the
    // PC is left at halt address + 4 and the state machine stops issuing.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (redirect) begin
            state_d = RUN;
            pc_d    = redirectTarget;
            count_d = '0;
            wrPtr_d = '0;
            rdPtr_d = '0;
        end else begin
            if (doPush) begin
                pc_d    = pc_q + 32'd4;
                wrPtr_d = wrPtr_q + PTR_ONE;
                if (isHalt) begin
                    state_d = HALTED;
                end
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + PTR_ONE;
            end
            case ({doPush, doPop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset back to PC_INIT and an
    // empty buffer; any request in flight at reset is simply forgotten.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            pc_q    <= PC_INIT;
            count_q <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Buffer storage. Contents need no reset because occupancy alone decides
    // whether the head is valid. Only the PC is stored; next-PC is derived
    // on the way out.
    always_ff @(posedge CLK) begin
        if (!RST && doPush) begin
            instrBuf_q[wrPtr_q] <= imemload;
            pcBuf_q[wrPtr_q]    <= pc_q;
        end
    end

    // Outputs. Everything except the address is forced low during reset so
    // neither memory nor decode sees activity from stale state.
    assign imemREN  = !RST && reqActive;
    assign imemaddr = pc_q;
    assign id_valid = !RST && bufNotEmpty;
    assign id_instr = RST ? 32'h0 : instrBuf_q[rdPtr_q];
    assign id_pc    = RST ? 32'h0 : pcBuf_q[rdPtr_q];
    assign id_npc   = RST ? 32'h0 : pcBuf_q[rdPtr_q] + 32'd4;
    assign halted   = !RST && (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//    Directed bench for fetch_unit with a 16-word instruction ROM that
//    answers combinationally; ihit is driven explicitly by the stimulus.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] imemload;
    logic        ihit;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_npc;
    logic        halted;

    logic [31:0] rom [16];

    int checkCount;
    int passCount;
    int failCount;

    fetch_unit dut (
        .CLK         (CLK),
        .RST         (RST),
        .imemREN     (imemREN),
        .imemaddr    (imemaddr),
        .imemload    (imemload),
        .ihit        (ihit),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc),
        .id_npc      (id_npc),
        .halted      (halted)
    );

    // 10 ns clock, first rising edge at 5 ns.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // The ROM answers whatever address is presented; ihit says when.
    assign imemload = rom[imemaddr[5:2]];

    // Drives every DUT input at once.
    task automatic applyStimulus(input logic rstV, input logic ihitV, input logic readyV,
                                 input logic redirV, input logic [31:0] rpcV);
        RST         = rstV;
        ihit        = ihitV;
        id_ready    = readyV;
        redirect    = redirV;
        redirect_pc = rpcV;
    endtask

    // Advances one clock and lands 1 ns after the edge, where outputs are stable.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One comparison: counts it and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;

        rom[0]  = 32'h241D0FFC;
        rom[1]  = 32'h0C00000A;
        rom[2]  = 32'h20010001;
        rom[3]  = 32'h20020002;
        rom[4]  = 32'h20030003;
        rom[5]  = 32'h20040004;
        rom[6]  = 32'h20050005;
        rom[7]  = 32'h20060006;
        rom[8]  = 32'h20070007;
        rom[9]  = 32'hFFFFFFFF;
        rom[10] = 32'h2008000A;
        rom[11] = 32'h2009000B;
        rom[12] = 32'h200A000C;
        rom[13] = 32'h200B000D;
        rom[14] = 32'h200C000E;
        rom[15] = 32'h200D000F;

        // ---- 1: reset, then streaming fetch with ihit and id_ready tied high
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("rst_imemREN", {31'h0, imemREN}, 32'h0);
        checkOutput("rst_id_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("rst_halted", {31'h0, halted}, 32'h0);
        checkOutput("rst_id_instr", id_instr, 32'h0);
        checkOutput("rst_id_pc", id_pc, 32'h0);
        RST = 1'b0;
        #1;
        checkOutput("t1_addr0", imemaddr, 32'h0);
        checkOutput("t1_ren0", {31'h0, imemREN}, 32'h1);
        tick();
        checkOutput("t1_addr4", imemaddr, 32'h4);
        checkOutput("t1_valid0", {31'h0, id_valid}, 32'h1);
        checkOutput("t1_instr0", id_instr, 32'h241D0FFC);
        checkOutput("t1_pc0", id_pc, 32'h0);
        checkOutput("t1_npc0", id_npc, 32'h4);
        tick();
        checkOutput("t1_addr8", imemaddr, 32'h8);
        checkOutput("t1_instr1", id_instr, 32'h0C00000A);
        checkOutput("t1_pc1", id_pc, 32'h4);
        checkOutput("t1_npc1", id_npc, 32'h8);

        // ---- 2: slow memory, ihit every third cycle
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        RST = 1'b0;
        tick();
        checkOutput("t2_hold_a", imemaddr, 32'h0);
        checkOutput("t2_hold_ren", {31'h0, imemREN}, 32'h1);
        checkOutput("t2_novalid_a", {31'h0, id_valid}, 32'h0);
        tick();
        checkOutput("t2_hold_b", imemaddr, 32'h0);
        checkOutput("t2_novalid_b", {31'h0, id_valid}, 32'h0);
        ihit = 1'b1;
        tick();
        checkOutput("t2_addr4", imemaddr, 32'h4);
        checkOutput("t2_valid", {31'h0, id_valid}, 32'h1);
        checkOutput("t2_pc0", id_pc, 32'h0);
        ihit = 1'b0;
        tick();
        checkOutput("t2_nodup", {31'h0, id_valid}, 32'h0);
        checkOutput("t2_addr4_hold", imemaddr, 32'h4);

        // ---- 3: decode stalled, buffer fills, then drains in order
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        RST = 1'b0;
        tick();
        tick();
        checkOutput("t3_full_ren", {31'h0, imemREN}, 32'h0);
        checkOutput("t3_full_addr", imemaddr, 32'h8);
        checkOutput("t3_head_pc", id_pc, 32'h0);
        tick();
        checkOutput("t3_stall_addr", imemaddr, 32'h8);
        checkOutput("t3_stall_pc", id_pc, 32'h0);
        id_ready = 1'b1;
        tick();
        checkOutput("t3_drain_pc4", id_pc, 32'h4);
        checkOutput("t3_drain_instr", id_instr, 32'h0C00000A);
        checkOutput("t3_resume_ren", {31'h0, imemREN}, 32'h1);
        tick();
        checkOutput("t3_resume_pc8", id_pc, 32'h8);
        checkOutput("t3_resume_instr", id_instr, 32'h20010001);
        checkOutput("t3_addrC", imemaddr, 32'hC);

        // ---- 4: redirect with a simultaneous ihit
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000002B);
        tick();
        checkOutput("t4_flush_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("t4_target", imemaddr, 32'h28);
        redirect = 1'b0;
        tick();
        checkOutput("t4_first_pc", id_pc, 32'h28);
        checkOutput("t4_first_instr", id_instr, 32'h2008000A);

        // ---- 5: straight-line run into HALT at 0x24, then wrong-path recovery
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("t5_valid", {31'h0, id_valid}, 32'h1);
            checkOutput("t5_pc", id_pc, 32'(i * 4));
            checkOutput("t5_instr", id_instr, rom[i]);
        end
        checkOutput("t5_halted", {31'h0, halted}, 32'h1);
        checkOutput("t5_ren_off", {31'h0, imemREN}, 32'h0);
        checkOutput("t5_pc_frozen", imemaddr, 32'h28);
        for (int i = 0; i < 20; i++) begin
            tick();
            checkOutput("t5_halt_ren", {31'h0, imemREN}, 32'h0);
        end
        checkOutput("t5_drained", {31'h0, id_valid}, 32'h0);
        checkOutput("t5_still_halted", {31'h0, halted}, 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000000C);
        tick();
        checkOutput("t5_unhalt", {31'h0, halted}, 32'h0);
        checkOutput("t5_resume_addr", imemaddr, 32'hC);
        checkOutput("t5_resume_ren", {31'h0, imemREN}, 32'h1);
        redirect = 1'b0;
        tick();
        checkOutput("t5_resume_pc", id_pc, 32'hC);

        // ---- 6: reset mid-fetch with a full buffer, then PC wrap
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        RST = 1'b0;
        tick();
        tick();
        checkOutput("t6_buffered", {31'h0, id_valid}, 32'h1);
        RST = 1'b1;
        #1;
        checkOutput("t6_rst_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("t6_rst_ren", {31'h0, imemREN}, 32'h0);
        tick();
        checkOutput("t6_rst_ren_b", {31'h0, imemREN}, 32'h0);
        RST = 1'b0;
        #1;
        checkOutput("t6_empty", {31'h0, id_valid}, 32'h0);
        checkOutput("t6_pcinit", imemaddr, 32'h0);
        checkOutput("t6_ren_on", {31'h0, imemREN}, 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF);
        tick();
        checkOutput("t6_top_addr", imemaddr, 32'hFFFFFFFC);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        checkOutput("t6_wrap_addr", imemaddr, 32'h0);
        checkOutput("t6_wrap_pc", id_pc, 32'hFFFFFFFC);
        checkOutput("t6_wrap_npc", id_npc, 32'h0);
        checkOutput("t6_wrap_instr", id_instr, 32'h200D000F);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
